aes_cipher_iter: RTL and testbench
==================================

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter MAX_NK, default 8: largest key size in 32-bit words; legal values 4, 6, 8.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port key_valid, input, 1: key load request.
REQ-005 SHALL have port key_ready, output, 1: key load accepted when key_valid && key_ready at a rising edge.
REQ-006 SHALL have port key_len, input, 2: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved.
REQ-007 SHALL have port key, input, MAX_NK*32: cipher key, MSB-aligned; byte 0 in bits [MSB:MSB-7]; unused low bits ignored.
REQ-008 SHALL have port key_err, output, 1: one-cycle pulse on a rejected key load.
REQ-009 SHALL have port in_valid, input, 1: plaintext block valid.
REQ-010 SHALL have port in_ready, output, 1: block accepted when in_valid && in_ready at a rising edge.
REQ-011 SHALL have port in, input, 128: plaintext; byte 0 in bits [127:120].
REQ-012 SHALL have port out_valid, output, 1: ciphertext valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts out when out_valid && out_ready.
REQ-014 SHALL have port out, output, 128: ciphertext, same byte order as in.
REQ-015 SHALL have port busy, output, 1: high in KEXP or ROUND.

Function
REQ-016 SHALL implement an FSM with states IDLE (no valid key), KEXP (key expansion), READY (key valid, waiting for data), ROUND (round iteration) and HOLD (result waiting for out_ready).
REQ-017 SHALL assert key_ready in IDLE unconditionally, and in READY only while in_valid is low, so that data has priority; key_ready SHALL be low in all other states.
REQ-018 SHALL assert in_ready only in READY.
REQ-019 SHALL, on key acceptance with a length that is reserved or has Nk > MAX_NK, pulse key_err, invalidate the stored key and go to IDLE.
REQ-020 SHALL, on a legal key acceptance:
  - load the first Nk schedule words in the acceptance cycle;
  - then generate one expanded word per cycle in KEXP, per FIPS-197 KeyExpansion, including the extra SubWord at i mod 8 == 4 for Nk = 8;
  - store all 4*(Nr+1) words, with Nr = 10, 12 or 14.
REQ-021 SHALL remain in KEXP for exactly 4*(Nr+1)-Nk cycles (40, 46 or 52), then enter READY.
REQ-022 SHALL, on block acceptance, load state = in XOR round key 0 and enter ROUND.
REQ-023 SHALL perform one full round per cycle in ROUND:
  - rounds 1..Nr-1: SubBytes, ShiftRows, MixColumns, AddRoundKey;
  - round Nr: omit MixColumns.
REQ-024 SHALL assert out_valid on the Nr-th rising edge after the acceptance edge (10, 12 or 14 cycles) and enter HOLD.
REQ-025 SHALL hold out and out_valid stable in HOLD until out_ready is high at a rising edge, then return to READY; in_ready SHALL NOT rise in the same cycle.
REQ-026 SHALL, when out_ready is already high at the edge that raises out_valid, still present out for one full cycle and then return to READY.
REQ-027 SHALL keep the stored key valid across any number of blocks until a new key load or reset.
REQ-028 SHALL ignore key_valid and in_valid in every state where the matching ready signal is low.
REQ-029 SHALL use combinational S-box lookup (16 state bytes + 4 schedule bytes per cycle); no multi-cycle S-box.

Reset
REQ-030 SHALL, while rst_n is low, immediately force:
  - state IDLE;
  - key_ready = 1; in_ready = 0, out_valid = 0, busy = 0, key_err = 0;
  - out = 0;
  - stored key invalid.
REQ-031 SHALL, on reset asserted mid-KEXP, mid-ROUND or in HOLD, discard all work; no out_valid SHALL follow reset release until a new key and block are accepted.

Verification
REQ-032 SHALL pass AES-128: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a; KEXP lasts 40 cycles; out_valid 10 cycles after acceptance.
REQ-033 SHALL pass AES-192: key 000102...1617, in 00112233445566778899aabbccddeeff -> out dda97ca4864cdfe06eaf70a0ec0d7191; 46 / 12 cycles.
REQ-034 SHALL pass AES-256: key 000102...1e1f, same in -> out 8ea2b7ca516745bfeafc49904b496089; 52 / 14 cycles.
REQ-035 SHALL pass back-pressure: out_ready held low 20 cycles after out_valid -> out stable, in_ready low throughout; out_ready pulse -> READY next cycle; a second block with the same key gives the correct result.
REQ-036 SHALL pass error and priority checks:
  - key_len = 11 -> key_err pulse, state IDLE, in_ready stays 0;
  - with MAX_NK = 4, key_len = 10 -> key_err pulse;
  - in_valid and key_valid both high in READY -> block accepted, key ignored.
REQ-037 SHALL pass reset: rst_n low at ROUND cycle 5 -> all outputs at reset values within the same cycle; after release, a new AES-128 load and block give the REQ-032 result.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock, on-chip key expansion.
// The expanded key persists across blocks until reloaded or reset.
module aes_cipher_iter #(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [1:0]           key_len,
  input  logic [MAX_NK*32-1:0] key,
  output logic                 key_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out,
  output logic                 busy
);

  localparam int NW = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    IDLE, KEXP, READY, ROUND, HOLD
  } state_t;

  // Entry x sits at bit 8*(255-x)+7, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] round_fn(
    input logic [127:0] s,
    input logic [127:0] rk,
    input logic         last
  );
    logic [127:0] sh;
    logic [127:0] mx;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sh[127-8*(4*c+r) -: 8] =
          sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mx[127-32*c -: 32] = last ?
        sh[127-32*c -: 32] :
        mix(sh[127-32*c -: 32]);
    end
    return mx ^ rk;
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    w [NW];
  logic [3:0]     nk, nr, nk_sel, rnd;
  logic [5:0]     widx, wlast;
  logic [2:0]     kpos;
  logic [7:0]     rcon;
  logic [127:0]   st, rk0, rkr, rnd_out;
  logic [31:0]    prev, back, rot, sw, temp, wnew;
  logic           key_acc, key_bad, in_acc;
  logic           kexp_done, round_last;

  always_comb begin
    unique case (key_len)
      2'b00:   nk_sel = 4'd4;
      2'b01:   nk_sel = 4'd6;
      2'b10:   nk_sel = 4'd8;
      default: nk_sel = 4'd0;
    endcase
  end

  assign key_bad = (nk_sel == 4'd0) ||
                   (nk_sel > MAX_NK_L);

  assign key_ready = (state_q == IDLE) ||
                     (state_q == READY && !in_valid);
  assign in_ready  = state_q == READY;
  assign out_valid = state_q == HOLD;
  assign busy      = (state_q == KEXP) ||
                     (state_q == ROUND);

  assign key_acc    = key_valid && key_ready;
  assign in_acc     = in_valid && in_ready;
  assign wlast      = {nr, 2'b11};
  assign kexp_done  = widx == wlast;
  assign round_last = rnd == nr;

  // Schedule word i from w[i-1] and w[i-Nk]; kpos tracks i mod Nk.
  always_comb begin
    prev = w[widx - 6'd1];
    back = w[widx - {2'b00, nk}];
    rot  = (kpos == 3'd0) ?
           {prev[23:0], prev[31:24]} : prev;
    for (int b = 0; b < 4; b++) begin
      sw[31-8*b -: 8] = sbox(rot[31-8*b -: 8]);
    end
    temp = prev;
    if (kpos == 3'd0) begin
      temp = sw ^ {rcon, 24'h0};
    end else if (nk == 4'd8 && kpos == 3'd4) begin
      temp = sw;
    end
    wnew = back ^ temp;
  end

  assign rk0 = {w[0], w[1], w[2], w[3]};
  assign rkr = {w[{rnd, 2'b00}], w[{rnd, 2'b01}],
                w[{rnd, 2'b10}], w[{rnd, 2'b11}]};
  assign rnd_out = round_fn(st, rkr, round_last);

  always_comb begin
    state_d = state_q;
    if (key_acc) begin
      state_d = key_bad ? IDLE : KEXP;
    end else if (in_acc) begin
      state_d = ROUND;
    end else begin
      unique case (state_q)
        KEXP:    if (kexp_done)  state_d = READY;
        ROUND:   if (round_last) state_d = HOLD;
        HOLD:    if (out_ready)  state_d = READY;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_err <= 1'b0;
      nk      <= 4'd4;
      nr      <= 4'd10;
      widx    <= 6'd4;
      kpos    <= 3'd0;
      rcon    <= 8'h01;
      rnd     <= 4'd1;
      st      <= '0;
      out     <= '0;
      for (int i = 0; i < NW; i++) begin
        w[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      key_err <= key_acc && key_bad;
      if (key_acc && !key_bad) begin
        nk   <= nk_sel;
        nr   <= nk_sel + 4'd6;
        widx <= {2'b00, nk_sel};
        kpos <= 3'd0;
        rcon <= 8'h01;
        for (int j = 0; j < MAX_NK; j++) begin
          if (j < int'(nk_sel)) begin
            w[j] <= key[MAX_NK*32-1-32*j -: 32];
          end
        end
      end else if (state_q == KEXP) begin
        w[widx] <= wnew;
        widx    <= kexp_done ? widx : widx + 6'd1;
        // nk[2:0]-1 gives Nk-1 for 4, 6 and 8 alike.
        kpos    <= (kpos == nk[2:0] - 3'd1) ?
                   3'd0 : kpos + 3'd1;
        if (kpos == 3'd0) begin
          rcon <= xt(rcon);
        end
      end
      if (in_acc) begin
        st  <= in ^ rk0;
        rnd <= 4'd1;
      end else if (state_q == ROUND) begin
        st  <= rnd_out;
        rnd <= round_last ? rnd : rnd + 4'd1;
        if (round_last) begin
          out <= rnd_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors,
// back-pressure, key errors, priority and async reset.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 =
    128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 =
    128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {
    128'h000102030405060708090a0b0c0d0e0f,
    128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {
    192'h000102030405060708090a0b0c0d0e0f1011121314151617,
    64'hfeedfacefeedface};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key = '0;
  logic         key_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] din = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] dout;
  logic         busy;

  logic         k4_valid = 1'b0;
  logic         k4_ready;
  logic [1:0]   k4_len = 2'b00;
  logic [127:0] k4_key = '0;
  logic         k4_err;
  logic         k4_in_ready;
  logic         k4_out_valid;
  logic [127:0] k4_out;
  logic         k4_busy;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_cipher_iter #(.MAX_NK(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_len   (key_len),
    .key       (key),
    .key_err   (key_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .busy      (busy)
  );

  aes_cipher_iter #(.MAX_NK(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (k4_valid),
    .key_ready (k4_ready),
    .key_len   (k4_len),
    .key       (k4_key),
    .key_err   (k4_err),
    .in_valid  (1'b0),
    .in_ready  (k4_in_ready),
    .in        (128'h0),
    .out_valid (k4_out_valid),
    .out_ready (1'b0),
    .out       (k4_out),
    .busy      (k4_busy)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(
    input logic [1:0]   len,
    input logic [255:0] k,
    input int           cyc,
    input string        tag
  );
    int cnt;
    check({tag, "_kready"}, 128'(key_ready), 128'd1);
    key_len   = len;
    key       = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    check({tag, "_kexp_cyc"}, 128'(cnt), 128'(cyc));
    check({tag, "_iready"}, 128'(in_ready), 128'd1);
  endtask

  task automatic encrypt(
    input logic [127:0] blk,
    input logic [127:0] exp,
    input int           lat,
    input string        tag
  );
    int cnt;
    din      = blk;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    key_valid = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'd1);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    check({tag, "_lat"}, 128'(cnt), 128'(lat));
    check({tag, "_out"}, dout, exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_clr"}, 128'(out_valid), 128'd0);
    check({tag, "_ready_again"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    int bad;

    #2 rst_n = 1'b0;
    #1;
    check("rst_kready", 128'(key_ready), 128'd1);
    check("rst_iready", 128'(in_ready), 128'd0);
    check("rst_ovalid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_kerr", 128'(key_err), 128'd0);
    check("rst_out", dout, 128'd0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    load_key(2'b00, K128, 40, "k128");
    encrypt(PT, C128, 10, "b128");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dout !== C128 || !out_valid || in_ready)
        bad++;
    end
    check("bp_hold", 128'(bad), 128'd0);
    consume("bp");

    encrypt(PT, C128, 10, "b128_2");
    consume("b128_2");

    key_len   = 2'b10;
    key       = K256;
    key_valid = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("prio_kready", 128'(key_ready), 128'd0);
    encrypt(PT, C128, 10, "prio");
    consume("prio");

    load_key(2'b01, K192, 46, "k192");
    out_ready = 1'b1;
    encrypt(PT, C192, 12, "b192");
    tick();
    out_ready = 1'b0;
    check("b192_ovalid_1cyc", 128'(out_valid), 128'd0);
    check("b192_ready", 128'(in_ready), 128'd1);

    load_key(2'b10, K256, 52, "k256");
    encrypt(PT, C256, 14, "b256");
    consume("b256");

    key_len   = 2'b11;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("rsv_kerr", 128'(key_err), 128'd1);
    check("rsv_iready", 128'(in_ready), 128'd0);
    check("rsv_kready", 128'(key_ready), 128'd1);
    check("rsv_busy", 128'(busy), 128'd0);
    tick();
    check("rsv_kerr_pulse", 128'(key_err), 128'd0);
    check("rsv_iready2", 128'(in_ready), 128'd0);

    k4_len   = 2'b10;
    k4_valid = 1'b1;
    tick();
    k4_valid = 1'b0;
    check("nk4_kerr", 128'(k4_err), 128'd1);
    check("nk4_iready", 128'(k4_in_ready), 128'd0);
    check("nk4_busy", 128'(k4_busy), 128'd0);

    load_key(2'b00, K128, 40, "k128r");
    din      = PT;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_kready", 128'(key_ready), 128'd1);
    check("mid_iready", 128'(in_ready), 128'd0);
    check("mid_ovalid", 128'(out_valid), 128'd0);
    check("mid_busy", 128'(busy), 128'd0);
    check("mid_kerr", 128'(key_err), 128'd0);
    check("mid_out", dout, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || in_ready || busy)
        bad++;
    end
    check("post_rst_quiet", 128'(bad), 128'd0);
    load_key(2'b00, K128, 40, "k128p");
    encrypt(PT, C128, 10, "b128p");
    consume("b128p");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
